ram_loader: RTL

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ram_loader.sv
// Loads DEPTH host bytes into a RAM over a shared 8-bit bus: address phase, host handshake, write phase.
// Optional macro LOADER_CHECKSUM_EN adds a modulo-256 running sum of the written bytes.
module ram_loader #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    inout  wire  [7:0] bus,
    output logic       addr_load,
    output logic       ram_write,
    output logic       busy,
    output logic       done,
    output logic [7:0] checksum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]            hold_q, hold_d;
    logic                  bus_en;
    logic [7:0]            bus_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (data_valid) begin
                    hold_d  = data_in;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The last address ends the sequence without advancing, so the counter never wraps.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Strobes and bus drive are masked while reset is high so an abort never emits a late write.
    always_comb begin
        addr_load  = (state_q == ST_ADDR) && !reset;
        ram_write  = (state_q == ST_WRITE) && !reset;
        data_ready = (state_q == ST_WAIT) && !reset;
        busy       = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
        done       = (state_q == ST_DONE);
        bus_en     = addr_load || ram_write;
        bus_out    = (state_q == ST_WRITE) ? hold_q : 8'(cnt_q);
    end

    assign bus = bus_en ? bus_out : 8'hzz;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       csum_clr, csum_acc;

    assign csum_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign csum_acc = (state_q == ST_WRITE);

    always_comb begin
        csum_d = csum_q;
        if (csum_clr) begin
            csum_d = 8'h00;
        end else if (csum_acc) begin
            csum_d = csum_q + hold_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
